// File: rtl/ser48_rx_if.sv
// Received-word handshake between the serial receiver and its consumer.
// The receiver drives data/valid; the consumer answers with ready.
interface ser48_rx_if;
  logic [47:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ser48_rx.sv
// 48-bit asynchronous serial receiver: start bit, 48 data bits LSB first, stop bit.
// Good words are presented through a valid/ready handshake; sticky flags report framing errors and overruns.
module ser48_rx #(
  parameter int BIT_PERIOD  = 1252,
  parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        err_clr,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun,
  ser48_rx_if.master  rx
);

  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg;
  logic          sync_reg;
  logic          din_s;
  logic          din_d;
  logic [CW-1:0] cnt_reg;
  logic [5:0]    bit_cnt_reg;
  logic [47:0]   shift_reg;
  logic [47:0]   data_reg;
  logic          valid_reg;
  logic          frame_err_reg;
  logic          overrun_reg;

  logic bit_end;
  logic half_end;
  logic stop_good;
  logic stop_bad;
  logic accept;

  assign bit_end   = (cnt_reg == CW'(BIT_PERIOD - 1));
  assign half_end  = (cnt_reg == CW'(HALF_PERIOD - 1));
  assign stop_good = (state_reg == STOP) && bit_end && din_s;
  assign stop_bad  = (state_reg == STOP) && bit_end && !din_s;
  assign accept    = valid_reg && rx.ready;

  assign busy      = (state_reg != IDLE);
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign rx.data   = data_reg;
  assign rx.valid  = valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sync_reg      <= 1'b1;
      din_s         <= 1'b1;
      din_d         <= 1'b1;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      sync_reg <= din;
      din_s    <= sync_reg;
      din_d    <= din_s;

      // A word arriving while the previous one is still held is dropped.
      if (stop_good && (!valid_reg || rx.ready)) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (accept) begin
        valid_reg <= 1'b0;
      end

      if (stop_good && valid_reg && !rx.ready) begin
        overrun_reg <= 1'b1;
      end else if (err_clr) begin
        overrun_reg <= 1'b0;
      end

      if (stop_bad) begin
        frame_err_reg <= 1'b1;
      end else if (err_clr) begin
        frame_err_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (din_d && !din_s) begin
            state_reg <= START;
          end
        end
        START: begin
          if (half_end) begin
            cnt_reg <= '0;
            if (!din_s) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            shift_reg <= {din_s, shift_reg[47:1]};
            if (bit_cnt_reg == 6'd47) begin
              state_reg <= STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser48_rx.sv
// Randomized and directed bench for ser48_rx against a frame-level reference model.
// The model tracks each transmitted frame by the clock edge its stop bit is sampled on.
module tb_ser48_rx;
  localparam int B = 16;
  localparam int H = 8;
  localparam int LAT_STOP = 3 + H + 49 * B;

  logic clk;
  logic rst_n;
  logic din;
  logic err_clr;
  logic ready;
  logic busy;
  logic frame_err;
  logic overrun;

  ser48_rx_if rx ();
  assign rx.ready = ready;

  ser48_rx #(.BIT_PERIOD(B), .HALF_PERIOD(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .err_clr   (err_clr),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx        (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_on = 1'b0;

  // Transaction log: start edge, kind (0 glitch, 1 good stop, 2 bad stop), word.
  int          ev_k    [0:127];
  int          ev_kind [0:127];
  logic [47:0] ev_word [0:127];
  int wr = 0;
  int rd = 0;

  logic [47:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_fe = 1'b0;
  logic        m_ov = 1'b0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int done_edge(input int i);
    return (ev_kind[i] == 0) ? ev_k[i] + 3 + H : ev_k[i] + LAT_STOP;
  endfunction

  always @(posedge clk) begin
    logic        ld;
    logic        sov;
    logic        sfe;
    logic [47:0] nw;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_data  = '0;
      m_valid = 1'b0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
      rd      = wr;
    end else begin
      ld  = 1'b0;
      sov = 1'b0;
      sfe = 1'b0;
      nw  = '0;
      while (rd < wr && done_edge(rd) <= cyc) begin
        if (done_edge(rd) == cyc) begin
          if (ev_kind[rd] == 1) begin
            if (!m_valid || ready) begin
              ld = 1'b1;
              nw = ev_word[rd];
            end else begin
              sov = 1'b1;
            end
          end else if (ev_kind[rd] == 2) begin
            sfe = 1'b1;
          end
        end
        rd++;
      end
      if (ld) begin
        m_data  = nw;
        m_valid = 1'b1;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      m_ov = sov ? 1'b1 : (err_clr ? 1'b0 : m_ov);
      m_fe = sfe ? 1'b1 : (err_clr ? 1'b0 : m_fe);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("data", rx.data, m_data);
      chk("valid", {47'd0, rx.valid}, {47'd0, m_valid});
      chk("frame_err", {47'd0, frame_err}, {47'd0, m_fe});
      chk("overrun", {47'd0, overrun}, {47'd0, m_ov});
      chk("busy", {47'd0, busy}, {47'd0, (rd < wr) && (cyc >= ev_k[rd] + 3)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_on) begin
      ready   = ($urandom_range(0, 3) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic check_reset_values();
    chk("rst_data", rx.data, 48'h0);
    chk("rst_valid", {47'd0, rx.valid}, 48'h0);
    chk("rst_busy", {47'd0, busy}, 48'h0);
    chk("rst_frame_err", {47'd0, frame_err}, 48'h0);
    chk("rst_overrun", {47'd0, overrun}, 48'h0);
  endtask

  // mode: 0 plain, 1 pin valid latency, 2 pulse ready in the stop-sample cycle
  task automatic send_frame(input logic [47:0] w, input bit stop_bit,
                            input int abort_bit, input int mode);
    int k;
    k = cyc;
    din = 1'b0;
    ev_k[wr]    = k;
    ev_kind[wr] = stop_bit ? 1 : 2;
    ev_word[wr] = w;
    wr++;
    $display("frame start=%0d word=%012h stop=%0d abort_bit=%0d", k, w, stop_bit, abort_bit);
    hold(B);
    for (int i = 0; i < 48; i++) begin
      din = w[i];
      if (i == abort_bit) begin
        hold(5);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        din = 1'b1;
        hold(3);
        rst_n = 1'b1;
        return;
      end
      hold(B);
    end
    din = stop_bit;
    for (int j = 0; j < B; j++) begin
      if (mode == 2) ready = (cyc == k + LAT_STOP - 1);
      tick();
      if (mode == 1 && cyc == k + LAT_STOP - 1) chk("lat_before", {47'd0, rx.valid}, 48'h0);
      if (mode == 1 && cyc == k + LAT_STOP) chk("lat_after", {47'd0, rx.valid}, 48'h1);
    end
    if (mode == 2) ready = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    din     = 1'b1;
    ready   = 1'b0;
    err_clr = 1'b0;
    hold(3);
    check_reset_values();
    rst_n = 1'b1;
    hold(B);

    send_frame(48'h007FFF3CF7D7, 1'b1, -1, 1);
    hold(B);
    chk("f1_data", rx.data, 48'h007FFF3CF7D7);
    chk("f1_valid", {47'd0, rx.valid}, 48'h1);
    chk("f1_frame_err", {47'd0, frame_err}, 48'h0);

    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("consume_valid", {47'd0, rx.valid}, 48'h0);
    chk("consume_data", rx.data, 48'h007FFF3CF7D7);
    send_frame(48'hFFFFFFFFFFFF, 1'b1, -1, 0);
    hold(B);
    chk("f2_data", rx.data, 48'hFFFFFFFFFFFF);

    ev_k[wr] = cyc; ev_kind[wr] = 0; ev_word[wr] = '0; wr++;
    $display("glitch start=%0d", cyc);
    din = 1'b0;
    hold(3);
    din = 1'b1;
    hold(2 * B);
    chk("glitch_busy", {47'd0, busy}, 48'h0);
    chk("glitch_valid", {47'd0, rx.valid}, 48'h1);
    chk("glitch_frame_err", {47'd0, frame_err}, 48'h0);

    send_frame(48'h000000000001, 1'b0, -1, 0);
    hold(5 * B);
    chk("bad_frame_err", {47'd0, frame_err}, 48'h1);
    chk("bad_valid", {47'd0, rx.valid}, 48'h1);
    chk("bad_data", rx.data, 48'hFFFFFFFFFFFF);
    chk("low_line_busy", {47'd0, busy}, 48'h0);
    din = 1'b1;
    hold(B);
    err_clr = 1'b1; ready = 1'b1;
    tick();
    err_clr = 1'b0; ready = 1'b0;
    chk("clr_frame_err", {47'd0, frame_err}, 48'h0);
    hold(2);

    send_frame(48'hA5A5A5A5A5A5, 1'b1, -1, 0);
    hold(B);
    send_frame(48'h123456789ABC, 1'b1, -1, 0);
    hold(B);
    chk("ovr_data", rx.data, 48'hA5A5A5A5A5A5);
    chk("ovr_flag", {47'd0, overrun}, 48'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovr_clr", {47'd0, overrun}, 48'h0);

    send_frame(48'h0F0F0F0F0F0F, 1'b1, -1, 2);
    hold(B);
    chk("same_cycle_data", rx.data, 48'h0F0F0F0F0F0F);
    chk("same_cycle_valid", {47'd0, rx.valid}, 48'h1);
    chk("same_cycle_overrun", {47'd0, overrun}, 48'h0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    hold(B);

    send_frame(48'h55AA55AA55AA, 1'b1, 20, 0);
    hold(B);
    chk("post_rst_busy", {47'd0, busy}, 48'h0);
    send_frame(48'h0000DEADBEEF, 1'b1, -1, 0);
    hold(B);
    chk("post_rst_data", rx.data, 48'h0000DEADBEEF);
    chk("post_rst_valid", {47'd0, rx.valid}, 48'h1);

    rnd_on = 1'b1;
    for (int n = 0; n < 12; n++) begin
      logic [47:0] w;
      w = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) begin
        ev_k[wr] = cyc; ev_kind[wr] = 0; ev_word[wr] = '0; wr++;
        $display("glitch start=%0d", cyc);
        din = 1'b0;
        hold($urandom_range(1, 4));
        din = 1'b1;
        hold(2 * B);
      end
      send_frame(w, ($urandom_range(0, 4) != 0), -1, 0);
      din = 1'b1;
      hold($urandom_range(1, 2 * B));
    end
    rnd_on  = 1'b0;
    ready   = 1'b0;
    err_clr = 1'b0;
    hold(B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
